// File: rtl/truth_table_sweeper_if.sv
// Stimulus/response bundle between truth_table_sweeper and the gate under test.
// master = sweeper side, slave = gate/environment side.
interface truth_table_sweeper_if;
  logic       start;
  logic       f;
  logic       a;
  logic       b;
  logic       c;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] table_bits;
  logic [7:0] mismatch;
  logic [3:0] fail_count;

  modport master (
    input  start, f,
    output a, b, c, busy, done, pass, table_bits, mismatch, fail_count
  );

  modport slave (
    output start, f,
    input  a, b, c, busy, done, pass, table_bits, mismatch, fail_count
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Sweeps {a,b,c} through all eight vectors, samples f after a settle time and
// checks it against EXPECTED. Define SWEEP_EARLY_ABORT_EN to stop at the first mismatch.
module truth_table_sweeper #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXPECTED      = 8'h45
) (
  input logic                   clk,
  input logic                   rst,
  truth_table_sweeper_if.master bus
);

  typedef enum logic [1:0] {StIdle, StWait, StSample, StReport} state_e;

  localparam int unsigned CntW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);

  state_e          state;
  logic [2:0]      idx;
  logic [CntW-1:0] cnt;

  logic       samp_bad;
  logic       sweep_last;
  logic [7:0] mis_upd;

  assign samp_bad = bus.f ^ EXPECTED[idx];
  assign mis_upd  = bus.mismatch | (8'(samp_bad) << idx);

`ifdef SWEEP_EARLY_ABORT_EN
  assign sweep_last = (idx == 3'd7) || samp_bad;
`else
  assign sweep_last = (idx == 3'd7);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= StIdle;
      idx            <= 3'd0;
      cnt            <= '0;
      bus.a          <= 1'b0;
      bus.b          <= 1'b0;
      bus.c          <= 1'b0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.table_bits <= 8'h00;
      bus.mismatch   <= 8'h00;
      bus.fail_count <= 4'd0;
    end else begin
      unique case (state)
        StIdle: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          if (bus.start) begin
            bus.table_bits        <= 8'h00;
            bus.mismatch          <= 8'h00;
            bus.fail_count        <= 4'd0;
            bus.pass              <= 1'b0;
            idx                   <= 3'd0;
            {bus.a, bus.b, bus.c} <= 3'b000;
            cnt                   <= '0;
            bus.busy              <= 1'b1;
            state                 <= StWait;
          end
        end
        StWait: begin
          if (cnt == CntLast) state <= StSample;
          else                cnt   <= cnt + CntW'(1);
        end
        StSample: begin
          bus.table_bits[idx] <= bus.f;
          bus.mismatch        <= mis_upd;
          bus.fail_count      <= bus.fail_count + 4'(samp_bad);
          if (sweep_last) begin
            bus.done <= 1'b1;
            bus.pass <= (mis_upd == 8'h00);
            state    <= StReport;
          end else begin
            idx                   <= idx + 3'd1;
            {bus.a, bus.b, bus.c} <= idx + 3'd1;
            cnt                   <= '0;
            state                 <= StWait;
          end
        end
        StReport: begin
          // START is ignored here; a held START is picked up on the next IDLE cycle.
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule
